// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_seq_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 16;
    localparam logic [DEFAULT_ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;
    localparam int unsigned STEP_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC: branch target when taken, otherwise PC plus zero-extended step.
module pc_next_calc
    import pc_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [STEP_W-1:0] step,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] next_pc_c
);

    logic [ADDR_W-1:0] step_ext_c;
    logic [ADDR_W-1:0] seq_pc_c;

    // Addition wraps naturally at 2^ADDR_W.
    always_comb begin
        step_ext_c = ADDR_W'(step);
        seq_pc_c   = pc + step_ext_c;
        next_pc_c  = br_taken ? br_target : seq_pc_c;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/issue sequencer: requests an instruction at PC, holds it in IR until
// downstream accepts, then advances PC by step or redirects on a taken branch.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STEP_W-1:0] step,
    input  logic              start,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [ADDR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] ir,
    output logic              ir_valid,
    input  logic              next_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic [ADDR_W-1:0] retired
);

    state_e            state;
    logic [ADDR_W-1:0] next_pc_c;

    pc_next_calc #(
        .ADDR_W (ADDR_W)
    ) u_next (
        .pc        (pc),
        .step      (step),
        .br_taken  (br_taken),
        .br_target (br_target),
        .next_pc_c (next_pc_c)
    );

    assign imem_addr = pc;

    // Outputs are registered alongside the state so they reflect the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            ir       <= '0;
            retired  <= '0;
            imem_req <= 1'b0;
            ir_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack) begin
                        state    <= ISSUE;
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        ir_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (next_ready) begin
                        pc       <= next_pc_c;
                        ir_valid <= 1'b0;
                        if (retired != {ADDR_W{1'b1}}) begin
                            retired <= retired + ADDR_W'(1);
                        end
                        // Halt parks in IDLE with PC already advanced, so a restart resumes there.
                        if (halt) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                    ir_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter ADDR_W, default 16, SHALL be the width of PC, addresses and instruction words.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 RST_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 STEP  in  4  SHALL be the PC increment amount, driven by the constant-1 four-bit generator; unsigned, zero-extended to ADDR_W.
REQ-006 START  in  1  SHALL request the start of fetching; effective in IDLE only.
REQ-007 IMEM_REQ  out  1  SHALL be the instruction-memory read request.
REQ-008 IMEM_ADDR  out  ADDR_W  SHALL be the fetch address; it equals PC.
REQ-009 IMEM_ACK  in  1  SHALL be memory's acknowledge; IMEM_RDATA is valid in the same cycle.
REQ-010 IMEM_RDATA  in  ADDR_W  SHALL be the returned instruction word.
REQ-011 IR  out  ADDR_W  SHALL be the captured instruction register.
REQ-012 IR_VALID  out  1  SHALL indicate IR holds an instruction offered downstream.
REQ-013 NEXT_READY  in  1  SHALL indicate the downstream stage accepts IR this cycle.
REQ-014 BR_TAKEN  in  1 and BR_TARGET  in  ADDR_W  SHALL select a redirect target at the issue handshake.
REQ-015 HALT  in  1  SHALL stop fetching after the current instruction issues.
REQ-016 PC  out  ADDR_W  SHALL be the current program counter.
REQ-017 BUSY  out  1  SHALL be 1 in any state other than IDLE.
REQ-018 RETIRED  out  ADDR_W  SHALL count completed issue handshakes.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, FETCH, ISSUE.
REQ-020 IDLE: IMEM_REQ=0, IR_VALID=0; START=1 -> FETCH next cycle.
REQ-021 FETCH: IMEM_REQ=1, held until IMEM_ACK; on IMEM_ACK, IR<=IMEM_RDATA and go to ISSUE.
REQ-022 ISSUE: IR_VALID=1, IR stable, held until NEXT_READY; IMEM_REQ=0.
REQ-023 Issue handshake (ISSUE and NEXT_READY): PC<=BR_TARGET if BR_TAKEN, else PC+zext(STEP) modulo 2^ADDR_W; RETIRED increments.
REQ-024 After the handshake: HALT=1 -> IDLE, else -> FETCH; first new IMEM_REQ one cycle after the handshake.
REQ-025 Minimum latency SHALL be 2 cycles per instruction: ACK in first FETCH cycle, NEXT_READY in first ISSUE cycle.
REQ-026 PC SHALL change only at an issue handshake or reset.
REQ-027 PC wrap: 16'hFFFF + 1 -> 16'h0000 with no error flag.
REQ-028 STEP=0 SHALL leave PC unchanged on a non-branch handshake.
REQ-029 BR_TAKEN, BR_TARGET and HALT SHALL be ignored outside the issue handshake cycle.
REQ-030 START outside IDLE SHALL be ignored; IMEM_ACK outside FETCH SHALL be ignored.
REQ-031 RETIRED SHALL saturate at all-ones.
REQ-032 After a HALT, START SHALL resume fetching from the updated PC, not RESET_PC.

Reset
REQ-033 RST_N low SHALL immediately force state=IDLE, PC=RESET_PC, IR=0, RETIRED=0, IMEM_REQ=0, IR_VALID=0, BUSY=0.
REQ-034 Reset asserted mid-FETCH or mid-ISSUE SHALL abandon the transaction; a late IMEM_ACK SHALL be ignored.
REQ-035 Reset deassertion SHALL take effect at the first rising CLK edge after RST_N rises.

Structure
REQ-036 Package pc_seq_pkg SHALL hold the state enum (IDLE/FETCH/ISSUE), ADDR_W and the RESET_PC default.
REQ-037 Next-PC logic (zero-extend, add, branch mux) SHALL be a combinational sub-module pc_next_calc; FSM and registers stay in pc_sequencer.

Verification
REQ-038 Reset, STEP=1, START pulse, ACK in 1st FETCH cycle, NEXT_READY=1 -> IMEM_ADDR sequence 0,1,2,3; RETIRED=3 after third handshake.
REQ-039 FETCH with ACK delayed 3 cycles -> IMEM_REQ high 4 cycles, IMEM_ADDR stable; IR=IMEM_RDATA captured on the ACK edge.
REQ-040 PC=16'h0010, NEXT_READY low 5 cycles then high with BR_TAKEN=1, BR_TARGET=16'h0200 -> IR_VALID held 6 cycles, IR stable; next IMEM_ADDR=16'h0200.
REQ-041 RESET_PC=16'hFFFF, STEP=1, one handshake -> PC=16'h0000.
REQ-042 HALT=1 at handshake with PC=5 -> IDLE, BUSY=0, PC=6; START -> IMEM_ADDR=6.
REQ-043 RST_N pulsed low mid-FETCH with PC=16'h0042 -> outputs reset asynchronously, PC=RESET_PC; subsequent stray IMEM_ACK has no effect.
